rvmemreq: RTL and testbench
===========================

# rvmemreq

Core-side memory request adapter that sits directly upstream of the DDR3 memory supervisor's split AXI-lite style port (waen/wden/raen/rden). It accepts one RV32I load/store per handshake, word-aligns the address, and generates byte masks and lane-replicated write data. It drives the address and data channels until the downstream side accepts them, then waits for the write response or read data. It returns an aligned, sign- or zero-extended result to the core; only one transaction is outstanding at a time.

## Interface
- MEM_ADDR_WIDTH, 32, address width on both sides
- MEM_DATA_WIDTH, 32, data width; fixed at 32 for RV32I
- MASK_WIDTH, MEM_DATA_WIDTH/8, byte-strobe width
- clock  in  1  single clock for all logic, shared with the downstream memory port
- resetn  in  1  asynchronous, active-low reset
- mem_ready  in  1  downstream initialisation done; no new request is accepted while low
- req_valid / req_ready  in / out  1 / 1  core request handshake
- req_fcn  in  1  0 = load, 1 = store
- req_typ  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are errors
- req_addr  in  MEM_ADDR_WIDTH  byte address
- req_data  in  MEM_DATA_WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  MEM_DATA_WIDTH  load result; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned access or illegal typ
- waen, wden  out  1  write address valid, write data valid (wden also serves as last)
- waddr  out  MEM_ADDR_WIDTH  {req_addr[31:2],2'b00}
- wdata / wmask  out  MEM_DATA_WIDTH / MASK_WIDTH  lane-replicated data and byte strobes
- wardy, wdrdy, wbvld  in  1  write address accept, write data accept, write response (always consumed)
- raen  out  1  read address valid
- rden  out  1  high while waiting for read data (informational)
- raddr  out  MEM_ADDR_WIDTH  word-aligned read address
- rdata  in  MEM_DATA_WIDTH  read data
- rardy, rdrdy  in  1  read address accept, read data valid (always consumed)

## Operation
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and all latches are cleared.
- req_ready = (state==IDLE) & mem_ready. On acceptance, fcn, typ, addr, and data are latched.
- Misalignment is checked at acceptance:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - An illegal typ is an error.
  - On any of these, the block goes to RESP with resp_err=1, and no downstream signal asserts.
- FSM states: IDLE, WREQ, WRSP, RREQ, RDAT, RESP.
  - IDLE→WREQ on an accepted store; IDLE→RREQ on an accepted load; IDLE→RESP on an error.
  - WREQ: waen and wden start high. waen clears on the cycle after wardy is sampled, and wden clears on the cycle after wdrdy is sampled; the two are independent and may be accepted in either order or together. The block moves to WRSP once both have been accepted.
  - WRSP: wait for wbvld, then go to RESP. wbvld is latched in any write state, so an early pulse is never lost.
  - RREQ: raen is high until rardy, then go to RDAT with rden=1.
  - RDAT: on rdrdy, rdata is captured, rden clears, and the block goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store masks and data (o = addr[1:0]):
  - B: wmask=1<<o, wdata={4{data[7:0]}}.
  - H: wmask=3<<o, wdata={2{data[15:0]}}.
  - W: wmask=4'hF, wdata=data.
- Load result: s = rdata >> (8·o).
  - B: sign-extend s[7:0]. BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]. HU: zero-extend s[15:0].
  - W: s.
- If mem_ready falls while a transaction is in flight, the transaction still completes; only new acceptance is blocked.
- resetn asserted mid-transaction abandons it immediately. The system guarantees that the downstream interconnect is reset in the same window.

## Timing
- Acceptance edge T0. Downstream valids are first high at T0+1.
- Load with zero-wait downstream (rardy at T0+1, rdrdy at T0+2): resp_valid at T0+3.
- Store with wardy and wdrdy at T0+1 and wbvld at T0+2: resp_valid at T0+3.
- Error: resp_valid at T0+1.
- Back-to-back throughput: the next req_ready is high the cycle after resp_valid. Minimum is 4 cycles per memory transaction.
- The block imposes no timeout; it waits indefinitely in each wait state.

## Test plan
- Reset then idle: with resetn low, all outputs are 0. After release with mem_ready=0, req_valid=1 is never accepted. After mem_ready rises, acceptance occurs on the next edge.
- Load SB/LB: store typ=B, addr=0x103, data=0x000000A5 → wmask=4'b1000, wdata=0xA5A5A5A5, waddr=0x100. Load typ=B from 0x103 with rdata=0xA5000000 → resp_data=0xFFFFFFA5. Same load with BU → 0x000000A5.
- Split write acceptance: wdrdy at T0+1 and wardy held off until T0+4 → wden drops at T0+2, waen drops at T0+5. resp_valid follows one cycle after wbvld; no duplicate beats.
- Stalled read: rardy delayed 5 cycles and rdrdy 7 cycles later; typ=HU, addr=0x206, rdata=0x8001xxxx → resp_data=0x00008001, exactly one resp_valid pulse.
- Misaligned and illegal: typ=W at addr=0x102, then typ=3'b011 → each gives resp_valid at T0+1 with resp_err=1 and resp_data=0; waen and raen are never asserted.
- Reset mid-write: assert resetn low while in WRSP → all outputs 0 and state IDLE. After release, a new load completes normally.

Source files
------------

// File: rtl/rvmemreq.sv
// RV32I load/store adapter toward a split address/data memory port.
// One transaction in flight; the result is lane-aligned and extended for the core.
module rvmemreq #(
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int MASK_WIDTH     = MEM_DATA_WIDTH / 8
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      mem_ready,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_fcn,
   input  logic [2:0]                req_typ,
   input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
   input  logic [MEM_DATA_WIDTH-1:0] req_data,
   output logic                      resp_valid,
   output logic [MEM_DATA_WIDTH-1:0] resp_data,
   output logic                      resp_err,
   output logic                      waen,
   output logic                      wden,
   output logic [MEM_ADDR_WIDTH-1:0] waddr,
   output logic [MEM_DATA_WIDTH-1:0] wdata,
   output logic [MASK_WIDTH-1:0]     wmask,
   input  logic                      wardy,
   input  logic                      wdrdy,
   input  logic                      wbvld,
   output logic                      raen,
   output logic                      rden,
   output logic [MEM_ADDR_WIDTH-1:0] raddr,
   input  logic [MEM_DATA_WIDTH-1:0] rdata,
   input  logic                      rardy,
   input  logic                      rdrdy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WREQ = 3'd1;
   localparam logic [2:0] S_WRSP = 3'd2;
   localparam logic [2:0] S_RREQ = 3'd3;
   localparam logic [2:0] S_RDAT = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   logic [2:0]                state_q, state_d;
   logic [2:0]                typ_q, typ_d;
   logic [1:0]                off_q, off_d;
   logic                      bvld_q, bvld_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [MEM_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                      resp_err_q, resp_err_d;
   logic                      waen_q, waen_d;
   logic                      wden_q, wden_d;
   logic [MEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0]     wmask_q, wmask_d;
   logic                      raen_q, raen_d;
   logic                      rden_q, rden_d;
   logic [MEM_ADDR_WIDTH-1:0] raddr_q, raddr_d;

   logic                      req_err;
   logic [MEM_ADDR_WIDTH-1:0] addr_al;

   function automatic logic [MEM_DATA_WIDTH-1:0] load_ext(
      input logic [MEM_DATA_WIDTH-1:0] rd,
      input logic [2:0]                typ,
      input logic [1:0]                off
   );
      logic [MEM_DATA_WIDTH-1:0] s;
      s = rd >> {off, 3'b000};
      case (typ)
         3'b000:  load_ext = {{(MEM_DATA_WIDTH-8){s[7]}}, s[7:0]};
         3'b100:  load_ext = {{(MEM_DATA_WIDTH-8){1'b0}}, s[7:0]};
         3'b001:  load_ext = {{(MEM_DATA_WIDTH-16){s[15]}}, s[15:0]};
         3'b101:  load_ext = {{(MEM_DATA_WIDTH-16){1'b0}}, s[15:0]};
         default: load_ext = s;
      endcase
   endfunction

   assign req_ready = (state_q == S_IDLE) & mem_ready;
   assign addr_al   = {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      case (req_typ)
         3'b000, 3'b100: req_err = 1'b0;
         3'b001, 3'b101: req_err = req_addr[0];
         3'b010:         req_err = (req_addr[1:0] != 2'b00);
         default:        req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      typ_d        = typ_q;
      off_d        = off_q;
      bvld_d       = bvld_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      waen_d       = waen_q;
      wden_d       = wden_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      raen_d       = raen_q;
      rden_d       = rden_q;
      raddr_d      = raddr_q;
      case (state_q)
         S_IDLE: if (req_valid && req_ready) begin
            typ_d       = req_typ;
            off_d       = req_addr[1:0];
            bvld_d      = 1'b0;
            resp_data_d = '0;
            resp_err_d  = 1'b0;
            if (req_err) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else if (req_fcn) begin
               state_d = S_WREQ;
               waen_d  = 1'b1;
               wden_d  = 1'b1;
               waddr_d = addr_al;
               case (req_typ[1:0])
                  2'b00: begin
                     wmask_d = MASK_WIDTH'(1) << req_addr[1:0];
                     wdata_d = {(MEM_DATA_WIDTH/8){req_data[7:0]}};
                  end
                  2'b01: begin
                     wmask_d = MASK_WIDTH'(3) << req_addr[1:0];
                     wdata_d = {(MEM_DATA_WIDTH/16){req_data[15:0]}};
                  end
                  default: begin
                     wmask_d = '1;
                     wdata_d = req_data;
                  end
               endcase
            end else begin
               state_d = S_RREQ;
               raen_d  = 1'b1;
               raddr_d = addr_al;
            end
         end
         S_WREQ: begin
            // address and data beats retire independently; a response may arrive early
            if (wardy) waen_d = 1'b0;
            if (wdrdy) wden_d = 1'b0;
            if (wbvld) bvld_d = 1'b1;
            if (!waen_d && !wden_d) state_d = S_WRSP;
         end
         S_WRSP: if (wbvld || bvld_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
         end
         S_RREQ: if (rardy) begin
            raen_d  = 1'b0;
            rden_d  = 1'b1;
            state_d = S_RDAT;
         end
         S_RDAT: if (rdrdy) begin
            rden_d       = 1'b0;
            resp_data_d  = load_ext(rdata, typ_q, off_q);
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            state_d     = S_IDLE;
            resp_err_d  = 1'b0;
            resp_data_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         typ_q        <= '0;
         off_q        <= '0;
         bvld_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         waen_q       <= 1'b0;
         wden_q       <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         raen_q       <= 1'b0;
         rden_q       <= 1'b0;
         raddr_q      <= '0;
      end else begin
         state_q      <= state_d;
         typ_q        <= typ_d;
         off_q        <= off_d;
         bvld_q       <= bvld_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         waen_q       <= waen_d;
         wden_q       <= wden_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         raen_q       <= raen_d;
         rden_q       <= rden_d;
         raddr_q      <= raddr_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign waen       = waen_q;
   assign wden       = wden_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign wmask      = wmask_q;
   assign raen       = raen_q;
   assign rden       = rden_q;
   assign raddr      = raddr_q;

endmodule

// File: tb/tb_rvmemreq.sv
// Directed bench for rvmemreq: hand-computed vectors, one comparison per check.
module tb_rvmemreq;

   logic        clock, resetn, mem_ready;
   logic        req_valid, req_ready, req_fcn;
   logic [2:0]  req_typ;
   logic [31:0] req_addr, req_data;
   logic        resp_valid, resp_err;
   logic [31:0] resp_data;
   logic        waen, wden, wardy, wdrdy, wbvld;
   logic [31:0] waddr, wdata;
   logic [3:0]  wmask;
   logic        raen, rden, rardy, rdrdy;
   logic [31:0] raddr, rdata;

   int n_cmp = 0;
   int n_err = 0;

   rvmemreq dut (
      .clock(clock), .resetn(resetn), .mem_ready(mem_ready),
      .req_valid(req_valid), .req_ready(req_ready), .req_fcn(req_fcn),
      .req_typ(req_typ), .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .waen(waen), .wden(wden), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .wardy(wardy), .wdrdy(wdrdy), .wbvld(wbvld),
      .raen(raen), .rden(rden), .raddr(raddr), .rdata(rdata),
      .rardy(rardy), .rdrdy(rdrdy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic accept(input logic f, input logic [2:0] typ, input logic [31:0] a, input logic [31:0] d);
      req_fcn   = f;
      req_typ   = typ;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   // zero-wait load; returns what is seen in the resp_valid cycle
   task automatic load0(input logic [2:0] typ, input logic [31:0] a, input logic [31:0] rd,
                        output logic v, output logic [31:0] d);
      accept(1'b0, typ, a, 32'h0);
      rardy = 1'b1;
      tick();
      rardy = 1'b0;
      rdrdy = 1'b1;
      rdata = rd;
      tick();
      rdrdy = 1'b0;
      v = resp_valid;
      d = resp_data;
      tick();
   endtask

   logic        v;
   logic [31:0] d;
   int          pulses;

   initial begin
      resetn = 1'b0; mem_ready = 1'b0; req_valid = 1'b0; req_fcn = 1'b0;
      req_typ = 3'b0; req_addr = '0; req_data = '0;
      wardy = 1'b0; wdrdy = 1'b0; wbvld = 1'b0; rardy = 1'b0; rdrdy = 1'b0; rdata = '0;
      tick(); tick();
      chk("rst_ctl", {25'b0, req_ready, resp_valid, resp_err, waen, wden, raen, rden}, 32'h0);
      chk("rst_data", waddr | wdata | raddr | resp_data | {28'b0, wmask}, 32'h0);

      // mem_ready low blocks acceptance
      resetn = 1'b1;
      req_fcn = 1'b0; req_typ = 3'b010; req_addr = 32'h40; req_valid = 1'b1;
      tick(); tick(); tick();
      chk("blocked_ready", {31'b0, req_ready}, 32'h0);
      chk("blocked_raen", {31'b0, raen}, 32'h0);
      mem_ready = 1'b1;
      #1;
      chk("ready_up", {31'b0, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      chk("lw_raen", {31'b0, raen}, 32'h1);
      chk("lw_raddr", raddr, 32'h40);
      chk("lw_busy", {31'b0, req_ready}, 32'h0);
      rardy = 1'b1;
      tick();
      rardy = 1'b0;
      chk("lw_rden", {30'b0, raen, rden}, 32'h1);
      rdrdy = 1'b1; rdata = 32'h12345678;
      tick();
      rdrdy = 1'b0;
      chk("lw_resp", {31'b0, resp_valid}, 32'h1);
      chk("lw_data", resp_data, 32'h12345678);
      chk("lw_err", {31'b0, resp_err}, 32'h0);
      tick();
      chk("lw_pulse_end", {30'b0, resp_valid, req_ready}, 32'h1);

      // SB to 0x103
      accept(1'b1, 3'b000, 32'h103, 32'h000000A5);
      chk("sb_valids", {30'b0, waen, wden}, 32'h3);
      chk("sb_waddr", waddr, 32'h100);
      chk("sb_wdata", wdata, 32'hA5A5A5A5);
      chk("sb_wmask", {28'b0, wmask}, 32'h8);
      wardy = 1'b1; wdrdy = 1'b1;
      tick();
      wardy = 1'b0; wdrdy = 1'b0;
      chk("sb_accepted", {29'b0, waen, wden, resp_valid}, 32'h0);
      wbvld = 1'b1;
      tick();
      wbvld = 1'b0;
      chk("sb_resp", {30'b0, resp_valid, resp_err}, 32'h2);
      chk("sb_rdata0", resp_data, 32'h0);
      tick();

      load0(3'b000, 32'h103, 32'hA5000000, v, d);
      chk("lb_valid", {31'b0, v}, 32'h1);
      chk("lb_data", d, 32'hFFFFFFA5);
      load0(3'b100, 32'h103, 32'hA5000000, v, d);
      chk("lbu_data", d, 32'h000000A5);
      load0(3'b001, 32'h102, 32'h80010000, v, d);
      chk("lh_data", d, 32'hFFFF8001);

      // SH at 0x102, data beat first, address beat late
      accept(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
      chk("sh_wmask", {28'b0, wmask}, 32'hC);
      chk("sh_wdata", wdata, 32'hBEEFBEEF);
      wdrdy = 1'b1;
      tick();
      wdrdy = 1'b0;
      chk("split_t2", {30'b0, waen, wden}, 32'h2);
      tick(); tick();
      chk("split_t4", {30'b0, waen, wden}, 32'h2);
      wardy = 1'b1;
      tick();
      wardy = 1'b0;
      chk("split_t5", {29'b0, waen, wden, resp_valid}, 32'h0);
      wbvld = 1'b1;
      tick();
      wbvld = 1'b0;
      chk("split_resp", {31'b0, resp_valid}, 32'h1);
      tick();
      chk("split_after", {29'b0, waen, wden, resp_valid}, 32'h0);

      // SW with write response arriving before both beats retire
      accept(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
      chk("sw_wdata", wdata, 32'hCAFEF00D);
      chk("sw_wmask", {28'b0, wmask}, 32'hF);
      wbvld = 1'b1;
      tick();
      wbvld = 1'b0; wardy = 1'b1; wdrdy = 1'b1;
      tick();
      wardy = 1'b0; wdrdy = 1'b0;
      chk("early_b_wait", {29'b0, waen, wden, resp_valid}, 32'h0);
      tick();
      chk("early_b_resp", {31'b0, resp_valid}, 32'h1);
      tick();

      // stalled LHU from 0x206
      pulses = 0;
      accept(1'b0, 3'b101, 32'h206, 32'h0);
      chk("hu_raddr", raddr, 32'h204);
      for (int i = 0; i < 5; i++) begin
         pulses += int'(resp_valid);
         tick();
      end
      chk("hu_raen_held", {30'b0, raen, rden}, 32'h2);
      rardy = 1'b1;
      tick();
      rardy = 1'b0;
      chk("hu_rden", {30'b0, raen, rden}, 32'h1);
      for (int i = 0; i < 7; i++) begin
         pulses += int'(resp_valid);
         tick();
      end
      rdata = 32'h8001BEEF; rdrdy = 1'b1;
      tick();
      rdrdy = 1'b0;
      chk("hu_data", resp_data, 32'h00008001);
      for (int i = 0; i < 4; i++) begin
         pulses += int'(resp_valid);
         tick();
      end
      chk("hu_pulses", pulses, 32'd1);

      // errors: misaligned W, illegal typ, misaligned SH
      accept(1'b0, 3'b010, 32'h102, 32'h0);
      chk("misw_resp", {30'b0, resp_valid, resp_err}, 32'h3);
      chk("misw_data", resp_data, 32'h0);
      chk("misw_quiet", {30'b0, waen, raen}, 32'h0);
      tick();
      chk("misw_done", {30'b0, resp_valid, req_ready}, 32'h1);
      accept(1'b0, 3'b011, 32'h100, 32'h0);
      chk("illegal_resp", {30'b0, resp_valid, resp_err}, 32'h3);
      chk("illegal_quiet", {30'b0, waen, raen}, 32'h0);
      tick();
      accept(1'b1, 3'b001, 32'h101, 32'hFFFF);
      chk("missh_resp", {29'b0, resp_valid, resp_err, wden}, 32'h6);
      tick();

      // reset while waiting for write response
      accept(1'b1, 3'b010, 32'h300, 32'h55AA55AA);
      wardy = 1'b1; wdrdy = 1'b1;
      tick();
      wardy = 1'b0; wdrdy = 1'b0;
      chk("pre_rst_wrsp", {30'b0, waen, wden}, 32'h0);
      resetn = 1'b0; mem_ready = 1'b0;
      #2;
      chk("midrst_ctl", {25'b0, req_ready, resp_valid, resp_err, waen, wden, raen, rden}, 32'h0);
      chk("midrst_data", waddr | wdata | {28'b0, wmask}, 32'h0);
      tick();
      resetn = 1'b1; mem_ready = 1'b1;
      #1;
      chk("postrst_idle", {31'b0, req_ready}, 32'h1);
      load0(3'b010, 32'h300, 32'h11223344, v, d);
      chk("postrst_lw", {v, d[30:0]}, {1'b1, 31'h11223344});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
